// File: rtl/issue_buffer_if.sv
// Handshake and decoded-head bundle between fetch, the issue buffer and the stall unit.
// master = fetch/control side, slave = the buffer itself.
interface issue_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic          flush;
    logic          stall;
    logic          issue_valid;
    logic [31:0]   issue_instr;
    logic [31:0]   issue_pc;
    logic [4:0]    reg_src_a;
    logic [4:0]    reg_src_b;
    logic [4:0]    reg_dest;
    logic [6:0]    opcode;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_instr, in_pc, flush, stall,
        input  in_ready, issue_valid, issue_instr, issue_pc,
               reg_src_a, reg_src_b, reg_dest, opcode, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, stall,
        output in_ready, issue_valid, issue_instr, issue_pc,
               reg_src_a, reg_src_b, reg_dest, opcode, count
    );
endinterface

// File: rtl/issue_buffer.sv
// Circular instruction issue buffer with combinational head decode for the stall unit.
// Optional same-cycle empty-buffer bypass enabled by defining ISSUE_BUFFER_BYPASS_EN.
module issue_buffer #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    issue_buffer_if.slave  bus
);
    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
    localparam logic [6:0]      OP_STORE  = 7'b0100011;
    localparam logic [6:0]      OP_BRANCH = 7'b1100011;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [63:0]   head_entry;

    always_comb begin
        empty = (count_q == '0);
`ifdef ISSUE_BUFFER_BYPASS_EN
        bypass = empty && bus.in_valid && !bus.stall && !bus.flush;
`else
        bypass = 1'b0;
`endif
        bus.in_ready    = (count_q < FULL_CNT) && !bus.flush;
        // A bypassed instruction issues directly and never occupies an entry.
        push            = bus.in_valid && bus.in_ready && !bypass;
        pop             = !empty && !bus.stall && !bus.flush;
        bus.issue_valid = pop || bypass;
        bus.count       = count_q;
    end

    // Head presentation: zeros when nothing is available so the stall unit sees no hazard.
    always_comb begin
        head_entry = 64'd0;
        if (bypass) begin
            head_entry = {bus.in_pc, bus.in_instr};
        end else if (!empty) begin
            head_entry = mem_q[rd_ptr_q];
        end
        bus.issue_pc    = head_entry[63:32];
        bus.issue_instr = head_entry[31:0];
        bus.opcode      = head_entry[6:0];
        bus.reg_src_a   = head_entry[19:15];
        bus.reg_src_b   = head_entry[24:20];
        bus.reg_dest    = head_entry[11:7];
        if (head_entry[6:0] == OP_STORE || head_entry[6:0] == OP_BRANCH) begin
            bus.reg_dest = 5'd0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left unreset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_pc, bus.in_instr};
        end
    end
endmodule

// File: tb/tb_issue_buffer.sv
// Self-checking bench for issue_buffer: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_issue_buffer;
    localparam int DEPTH = 4;
`ifdef ISSUE_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_buffer_if #(.DEPTH(DEPTH)) bus ();
    issue_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [63:0] model_q[$];
    logic        exp_push, exp_pop, exp_flush;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_dest(input logic [31:0] ins);
        if (ins[6:0] == 7'b0100011 || ins[6:0] == 7'b1100011) return 5'd0;
        return ins[11:7];
    endfunction

    // Drive one cycle's inputs, let them settle, compare everything against the model.
    task automatic apply(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic st);
        int n;
        logic byp, rdy, iv_exp;
        logic [63:0] head;
        bus.in_valid = iv;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        bus.flush    = fl;
        bus.stall    = st;
        #1;
        n      = model_q.size();
        byp    = BYP && (n == 0) && iv && !st && !fl;
        rdy    = (n < DEPTH) && !fl;
        iv_exp = ((n > 0) && !st && !fl) || byp;
        head   = byp ? {pc, ins} : ((n > 0) ? model_q[0] : 64'd0);
        check_eq("in_ready",    64'(bus.in_ready), 64'(rdy));
        check_eq("issue_valid", 64'(bus.issue_valid), 64'(iv_exp));
        check_eq("count",       64'(bus.count), 64'(n));
        check_eq("issue_pc",    64'(bus.issue_pc), 64'(head[63:32]));
        check_eq("issue_instr", 64'(bus.issue_instr), 64'(head[31:0]));
        check_eq("opcode",      64'(bus.opcode), 64'(head[6:0]));
        check_eq("reg_src_a",   64'(bus.reg_src_a), 64'(head[19:15]));
        check_eq("reg_src_b",   64'(bus.reg_src_b), 64'(head[24:20]));
        check_eq("reg_dest",    64'(bus.reg_dest), 64'(ref_dest(head[31:0])));
        exp_push  = iv && rdy && !byp;
        exp_pop   = iv_exp && !byp;
        exp_flush = fl;
        $display("cyc t=%0t iv=%0b st=%0b fl=%0b n=%0d issue=%0b instr=%08h",
                 $time, iv, st, fl, n, bus.issue_valid, bus.issue_instr);
    endtask

    task automatic tick();
        @(posedge clk);
        if (exp_flush) begin
            model_q.delete();
        end else begin
            if (exp_pop) void'(model_q.pop_front());
            if (exp_push) model_q.push_back({bus.in_pc, bus.in_instr});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        apply(1'b0, 32'd0, 32'd0, 1'b0, st);
        tick();
    endtask

    initial begin
        logic [31:0] ins, pc;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        bus.in_pc    = 32'd0;
        bus.flush    = 1'b0;
        bus.stall    = 1'b0;
        #12;
        @(negedge clk);
        check_eq("rst_count", 64'(bus.count), 64'd0);
        check_eq("rst_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_valid", 64'(bus.issue_valid), 64'd0);
        rst_n = 1'b1;

        // Single add, no stall: issue on the following cycle (same cycle when bypassed).
        apply(1'b1, 32'h00208033, 32'h100, 1'b0, 1'b0);
        check_eq("add_bypass_valid", 64'(bus.issue_valid), 64'(BYP));
        tick();
        apply(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        if (!BYP) begin
            check_eq("add_valid", 64'(bus.issue_valid), 64'd1);
            check_eq("add_src_a", 64'(bus.reg_src_a), 64'd1);
            check_eq("add_src_b", 64'(bus.reg_src_b), 64'd2);
            check_eq("add_dest",  64'(bus.reg_dest), 64'd0);
            check_eq("add_op",    64'(bus.opcode), 64'h33);
        end
        tick();
        apply(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check_eq("add_count_end", 64'(bus.count), 64'd0);
        tick();

        // Fill under stall, then drain in order on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 32'h00000013 | (32'(i + 1) << 7), 32'h200 + 32'(4 * i), 1'b0, 1'b1);
            tick();
        end
        apply(1'b1, 32'h00000033, 32'h300, 1'b0, 1'b1);
        check_eq("full_count", 64'(bus.count), 64'd4);
        check_eq("full_ready", 64'(bus.in_ready), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            check_eq("drain_valid", 64'(bus.issue_valid), 64'd1);
            check_eq("drain_pc",    64'(bus.issue_pc), 64'(32'h200 + 32'(4 * i)));
            tick();
        end

        // Store held at head under a three-cycle stall.
        apply(1'b1, 32'h00532023, 32'h400, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            check_eq("sw_instr", 64'(bus.issue_instr), 64'h00532023);
            check_eq("sw_valid", 64'(bus.issue_valid), 64'd0);
            check_eq("sw_dest",  64'(bus.reg_dest), 64'd0);
            check_eq("sw_src_b", 64'(bus.reg_src_b), 64'd5);
            tick();
        end
        idle(1'b0);

        // Flush with three entries and an offered instruction.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h00100093, 32'h500 + 32'(4 * i), 1'b0, 1'b1);
            tick();
        end
        apply(1'b1, 32'h00200113, 32'h600, 1'b1, 1'b1);
        check_eq("flush_ready", 64'(bus.in_ready), 64'd0);
        tick();
        apply(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check_eq("flush_count", 64'(bus.count), 64'd0);
        check_eq("flush_valid", 64'(bus.issue_valid), 64'd0);
        tick();

        // Asynchronous reset between edges with two entries held.
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 32'h00300193, 32'h700 + 32'(4 * i), 1'b0, 1'b1);
            tick();
        end
        apply(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_count", 64'(bus.count), 64'd0);
        check_eq("arst_valid", 64'(bus.issue_valid), 64'd0);
        check_eq("arst_instr", 64'(bus.issue_instr), 64'd0);
        model_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[6:0] = 7'b0100011;
                1: ins[6:0] = 7'b1100011;
                default: ;
            endcase
            pc = $urandom & 32'hFFFF_FFFC;
            apply($urandom_range(0, 9) < 7, ins, pc,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_buffer.md
ISSUE_BUFFER -- requirements
Module: issue_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries held (power of two, 2..16).
REQ-002 clk  input  1  pipeline clock, all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_ready  output  1  buffer accepts an instruction this cycle.
REQ-006 in_instr  input  32  fetched RV32 instruction word.
REQ-007 in_pc  input  32  PC of in_instr.
REQ-008 flush  input  1  discard all buffered instructions (branch redirect).
REQ-009 stall  input  1  hazard stall from the stall unit; head must not issue.
REQ-010 issue_valid  output  1  head instruction issues this cycle.
REQ-011 issue_instr  output  32, issue_pc  output  32  head instruction and PC.
REQ-012 reg_src_a  output  5, reg_src_b  output  5, reg_dest  output  5, opcode  output  7  decoded head fields to the stall unit.
REQ-013 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-014 Circular FIFO; write pointer, read pointer, count; pointers wrap modulo DEPTH.
REQ-015 in_ready SHALL be (count < DEPTH) && !flush, combinational.
REQ-016 Push when in_valid && in_ready; entry stores {in_pc, in_instr}.
REQ-017 Head fields SHALL be combinational from the read-pointer entry when count > 0.
REQ-018 Decode: reg_src_a = instr[19:15]; reg_src_b = instr[24:20]; opcode = instr[6:0]; reg_dest = instr[11:7], forced 0 for opcode 0100011 (store) and 1100011 (branch).
REQ-019 When count == 0 (and no bypass, REQ-029) issue_instr, issue_pc, reg_src_a, reg_src_b, reg_dest, opcode SHALL all be 0, so the stall unit sees no dependency.
REQ-020 issue_valid = (count > 0) && !stall && !flush; pop on the same edge when issue_valid is 1.
REQ-021 While stall = 1 the head SHALL be held unchanged and re-presented every cycle (bubble, issue_valid = 0).
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-023 Full (count == DEPTH): in_ready = 0 even if a pop occurs that cycle.
REQ-024 flush = 1: on the next edge count, read and write pointers SHALL return to 0; no push or pop occurs that cycle; flush takes priority over stall.
REQ-025 Latency without bypass: instruction pushed at edge N is earliest issued in cycle N+1.
REQ-026 Issue order SHALL equal push order; no instruction dropped or duplicated except by flush.

Reset
REQ-027 rst_n = 0 SHALL immediately clear count and both pointers, giving in_ready = 1, issue_valid = 0, all decoded outputs 0; entry storage is not cleared.
REQ-028 Reset asserted mid-stall or mid-push SHALL discard all contents; first push after release is the first issued.

Configuration
REQ-029 ISSUE_BUFFER_BYPASS_EN defined: when count == 0, in_valid = 1, stall = 0, flush = 0, the incoming instruction SHALL issue combinationally the same cycle (outputs decoded from in_instr/in_pc, issue_valid = 1) and SHALL NOT be stored; if stall = 1 it is pushed normally.
REQ-030 ISSUE_BUFFER_BYPASS_EN undefined: no bypass path; REQ-019 and REQ-025 apply unconditionally.

Verification
REQ-031 Reset, push 0x00208033 (add x0,x1,x2) at PC 0x100 with stall = 0 -> next cycle issue_valid = 1, reg_src_a = 1, reg_src_b = 2, reg_dest = 0, opcode = 0x33, count returns to 0.
REQ-032 Push 4 instructions with stall = 1 (DEPTH = 4) -> count = 4, in_ready = 0; drop stall -> four issues in push order on four consecutive cycles.
REQ-033 Hold stall = 1 for 3 cycles with head sw x5,0(x6) (0x00532023) -> head stable, issue_valid = 0, reg_dest = 0, reg_src_b = 5.
REQ-034 Buffer at count = 3, assert flush with in_valid = 1 -> next cycle count = 0, the offered instruction was not accepted, issue_valid = 0.
REQ-035 Assert rst_n = 0 between clock edges with count = 2 -> count = 0 and issue_valid = 0 before the next edge.
REQ-036 With ISSUE_BUFFER_BYPASS_EN: empty buffer, in_valid = 1, stall = 0 -> issue_valid = 1 in the same cycle, count stays 0; without the macro -> issue next cycle.
